// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default frame geometry and frame-length helper.
// The state set depends on UART_TX_PARITY_EN, so the receiver and transmitter agree on the encoding.
`timescale 1ns/1ps
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_WIDTH = 8;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } uart_state_t;
    localparam int UART_PARITY_BITS = 1;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;
    localparam int UART_PARITY_BITS = 0;
`endif

    // Total BLCK cycles from the first start-bit cycle to the last stop-bit cycle.
    function automatic int uart_frame_cycles(input int oversample, input int data_width,
                                             input int stop_bits);
        return (1 + data_width + UART_PARITY_BITS + stop_bits) * oversample;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample tick counter: counts 0..OVERSAMPLE-1, pulses bit_end on the last tick of each bit.
// clear holds the count at zero so the first bit after an idle period gets full length.
`timescale 1ns/1ps
module uart_bit_timer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic BLCK,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int TICK_W = $clog2(OVERSAMPLE);

    logic [TICK_W-1:0] tick_reg;
    logic [TICK_W-1:0] tick_next;

    assign bit_end = (tick_reg == TICK_W'(OVERSAMPLE - 1));

    always_comb begin
        tick_next = tick_reg + 1'b1;
        if (clear || bit_end) begin
            tick_next = '0;
        end
    end

    always_ff @(posedge BLCK) begin
        if (!reset) begin
            tick_reg <= '0;
        end else begin
            tick_reg <= tick_next;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to add the parity bit (PARITY_ODD selects odd parity).
`timescale 1ns/1ps
module uart_tx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int STOP_BITS  = 1,
`ifdef UART_TX_PARITY_EN
    parameter bit PARITY_ODD = 1'b0,
`endif
    parameter int DATA_BITS  = $clog2(DATA_WIDTH)
) (
    input  logic                  BLCK,
    input  logic                  reset,
    input  logic                  tx_start,
    input  logic [DATA_WIDTH-1:0] tx_din,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done_tk
);

    localparam int IDX_W = (DATA_BITS < 1) ? 1 : DATA_BITS;

    uart_state_t           state_reg, state_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic                  tx_reg, tx_next;
    logic                  timer_clear;
    logic                  bit_end;
    logic                  last_data;
    logic                  last_stop;
`ifdef UART_TX_PARITY_EN
    logic                  parity_reg, parity_next;
`endif

    uart_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_bit_timer (
        .BLCK   (BLCK),
        .reset  (reset),
        .clear  (timer_clear),
        .bit_end(bit_end)
    );

    // The bit index is reused to count stop bits once the data bits are out.
    assign last_data = (idx_reg == IDX_W'(DATA_WIDTH - 1));
    assign last_stop = (idx_reg == IDX_W'(STOP_BITS - 1));

    always_comb begin
        state_next  = state_reg;
        shift_next  = shift_reg;
        idx_next    = idx_reg;
        timer_clear = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                timer_clear = 1'b1;
                if (tx_start) begin
                    shift_next = tx_din;
                    idx_next   = '0;
                    state_next = START;
`ifdef UART_TX_PARITY_EN
                    parity_next = (^tx_din) ^ PARITY_ODD;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    idx_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (last_data) begin
                        idx_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    idx_next   = '0;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (last_stop) begin
                        state_next = IDLE;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Line level is decoded from the next state and registered, so tx never glitches.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = parity_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge BLCK) begin
        if (!reset) begin
            state_reg  <= IDLE;
            shift_reg  <= '0;
            idx_reg    <= '0;
            tx_reg     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            shift_reg  <= shift_next;
            idx_reg    <= idx_next;
            tx_reg     <= tx_next;
`ifdef UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    assign tx         = tx_reg;
    assign tx_busy    = (state_reg != IDLE);
    assign tx_done_tk = (state_reg == STOP) && bit_end && last_stop;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a bench-side line decoder pops expected words from a scoreboard.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * OS;

    logic       BLCK     = 1'b0;
    logic       reset    = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_din   = 8'h00;
    logic       tx;
    logic       tx_busy;
    logic       tx_done_tk;

    int n_cmp    = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic [7:0]    exp_q[$];
    logic [NB-1:0] last_bits;

    uart_tx dut (
        .BLCK      (BLCK),
        .reset     (reset),
        .tx_start  (tx_start),
        .tx_din    (tx_din),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .tx_done_tk(tx_done_tk)
    );

    always #5 BLCK = ~BLCK;

    always @(posedge BLCK) begin
        if (tx_done_tk === 1'b1) done_cnt++;
    end

    // Expected line levels, index 0 = start bit.
    function automatic logic [NB-1:0] frame_bits(input logic [7:0] w);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^w, w, 1'b0};
`else
        return {1'b1, w, 1'b0};
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge of the first frame cycle (one cycle after acceptance).
    task automatic send_word(input logic [7:0] w, input bit hold);
        @(negedge BLCK);
        tx_start = 1'b1;
        tx_din   = w;
        @(negedge BLCK);
        if (!hold) tx_start = 1'b0;
        check("accept_tx_low", {31'd0, tx}, 32'd0);
        check("accept_busy", {31'd0, tx_busy}, 32'd1);
        $display("send 0x%02h", w);
    endtask

    // Samples FRAME cycles starting at the current negedge (frame cycle 1).
    task automatic rx_frame(input string tag, input int inject_at, input logic [7:0] inject_val);
        logic [NB-1:0] bits;
        logic [NB-1:0] exp_bits;
        logic [7:0]    w;
        logic          cur;
        bit            stable;
        int            done_at;
        int            pulses;
        bits    = '0;
        cur     = 1'b0;
        stable  = 1'b1;
        done_at = -1;
        pulses  = 0;
        for (int c = 1; c <= FRAME; c++) begin
            if (c > 1) @(negedge BLCK);
            if (c == inject_at) begin
                tx_start = 1'b1;
                tx_din   = inject_val;
            end else if (inject_at > 0 && c == inject_at + 1) begin
                tx_start = 1'b0;
            end
            if ((c - 1) % OS == 0) begin
                cur = tx;
                bits[(c - 1) / OS] = tx;
            end else if (tx !== cur) begin
                stable = 1'b0;
            end
            if (tx_done_tk === 1'b1) begin
                pulses++;
                if (done_at < 0) done_at = c;
            end
        end
        last_bits = bits;
        check({tag, "_sb_size"}, exp_q.size(), 32'd1);
        if (exp_q.size() > 0) begin
            w        = exp_q.pop_front();
            exp_bits = frame_bits(w);
            check({tag, "_bits"}, 32'(bits), 32'(exp_bits));
            $display("frame %s: exp 0x%02h line %b done@%0d", tag, w, bits, done_at);
        end
        check({tag, "_bit_stable"}, {31'd0, stable}, 32'd1);
        check({tag, "_done_cycle"}, done_at, FRAME);
        check({tag, "_done_pulses"}, pulses, 32'd1);
    endtask

    initial begin
        logic [NB-1:0] a5_line;
        logic [7:0]    w;
        int            d0;
        int            lows;
        int            busys;

        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge BLCK);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, tx_busy}, 32'd0);
        check("reset_done", {31'd0, tx_done_tk}, 32'd0);
        reset = 1'b1;

        // 0xA5: exact line sequence and done timing
        send_word(8'hA5, 1'b0);
        exp_q.push_back(8'hA5);
        rx_frame("a5", 0, 8'h00);
`ifdef UART_TX_PARITY_EN
        a5_line = 11'b10101001010;
`else
        a5_line = 10'b1101001010;
`endif
        check("a5_line", 32'(last_bits), 32'(a5_line));

`ifdef UART_TX_PARITY_EN
        send_word(8'h07, 1'b0);
        exp_q.push_back(8'h07);
        rx_frame("p07", 0, 8'h00);
        check("p07_parity", {31'd0, last_bits[9]}, 32'd1);
`endif

        // tx_start while busy is ignored and not queued
        send_word(8'h5A, 1'b0);
        exp_q.push_back(8'h5A);
        rx_frame("busy_ignore", 30, 8'h3C);
        lows  = 0;
        busys = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge BLCK);
            if (tx !== 1'b1) lows++;
            if (tx_busy !== 1'b0) busys++;
        end
        check("no_second_frame_tx", lows, 32'd0);
        check("no_second_frame_busy", busys, 32'd0);

        // Back-to-back frames with tx_start held high
        d0 = done_cnt;
        send_word(8'h00, 1'b1);
        exp_q.push_back(8'h00);
        tx_din = 8'hFF;
        rx_frame("b2b_00", 0, 8'h00);
        @(negedge BLCK);
        check("b2b_gap_tx", {31'd0, tx}, 32'd1);
        check("b2b_gap_busy", {31'd0, tx_busy}, 32'd0);
        @(negedge BLCK);
        tx_start = 1'b0;
        check("b2b_second_start_tx", {31'd0, tx}, 32'd0);
        check("b2b_second_busy", {31'd0, tx_busy}, 32'd1);
        exp_q.push_back(8'hFF);
        rx_frame("b2b_ff", 0, 8'h00);
        @(negedge BLCK);
        check("b2b_done_count", done_cnt - d0, 32'd2);

        // Reset at cycle 50 of a frame aborts it
        send_word(8'hC3, 1'b0);
        repeat (49) @(negedge BLCK);
        reset = 1'b0;
        @(negedge BLCK);
        check("midreset_tx", {31'd0, tx}, 32'd1);
        check("midreset_busy", {31'd0, tx_busy}, 32'd0);
        reset = 1'b1;
        send_word(8'h96, 1'b0);
        exp_q.push_back(8'h96);
        rx_frame("after_reset", 0, 8'h00);

        // Random loopback
        for (int i = 0; i < 256; i++) begin
            w = 8'($urandom_range(0, 255));
            send_word(w, 1'b0);
            exp_q.push_back(w);
            rx_frame("rand", 0, 8'h00);
        end
        check("sb_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
